// File: rtl/spi_flash_pkg.sv
// Opcodes, FSM state encoding and status-register bit positions shared by the
// spi_flash_resp responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_SE   = 8'h20;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_RDID = 8'h9F;

   localparam int unsigned SR_WIP = 0;
   localparam int unsigned SR_WEL = 1;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StRdData,
      StPpData,
      StTxFixed,
      StIgnore,
      StErase
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for an asynchronous input with rise/fall pulses derived from
// the synchronized value and its one-cycle-delayed copy.
module spi_sync_edge (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 serial NOR flash responder backed by a byte-wide synchronous RAM port.
// Define SPI_FLASH_RESP_ERASE_EN to enable 0x20 sector erase (4 KiB, 0xFF fill).
module spi_flash_resp
   import spi_flash_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              sck_i,
   input  logic              csn_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              busy_o
);

   logic sck_rise, sck_fall;
   logic csn_meta_q, csn_q, mosi_meta_q, mosi_q;

   state_e            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [6:0]        shift_in_q, shift_in_d;
   logic [7:0]        shift_out_q, shift_out_d;
   logic              miso_q, miso_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-9:0] addr_sh_q, addr_sh_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wel_q, wel_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d, rd_cap_q, rd_cap_d;

   logic              wip;
   logic [7:0]        status, byte_in;
   logic [ADDR_W-1:0] addr_full;

`ifdef SPI_FLASH_RESP_ERASE_EN
   logic        wip_q, wip_d, se_pend_q, se_pend_d;
   logic [11:0] erase_cnt_q, erase_cnt_d;
   assign wip = wip_q;
`else
   assign wip = 1'b0;
`endif

   spi_sync_edge u_sck_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (sck_i),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         csn_meta_q  <= 1'b1;
         csn_q       <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         csn_meta_q  <= csn_i;
         csn_q       <= csn_meta_q;
         mosi_meta_q <= mosi_i;
         mosi_q      <= mosi_meta_q;
      end
   end

   assign byte_in   = {shift_in_q, mosi_q};
   assign addr_full = {addr_sh_q, byte_in};

   always_comb begin
      status         = 8'h00;
      status[SR_WIP] = wip;
      status[SR_WEL] = wel_q;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      miso_d      = miso_q;
      op_d        = op_q;
      addr_sh_d   = addr_sh_q;
      ptr_d       = ptr_q;
      wel_d       = wel_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rd_cap_d    = mem_re_q;
`ifdef SPI_FLASH_RESP_ERASE_EN
      wip_d       = wip_q;
      se_pend_d   = se_pend_q;
      erase_cnt_d = erase_cnt_q;
`endif
      // RAM data is valid the cycle after the read strobe.
      if (rd_cap_q) shift_out_d = mem_rdata_i;

      case (state_q)
         StIdle: begin
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            shift_out_d = '0;
            miso_d      = 1'b0;
            if (!csn_q) state_d = StCmd;
         end
`ifdef SPI_FLASH_RESP_ERASE_EN
         StErase: begin
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            shift_out_d = '0;
            miso_d      = 1'b0;
            if (!csn_q) state_d = StCmd;
            else if (!wip_q) state_d = StIdle;
         end
`endif
         default: begin
            if (sck_fall) begin
               miso_d      = shift_out_q[7];
               shift_out_d = {shift_out_q[6:0], 1'b0};
            end
            if (sck_rise) begin
               shift_in_d = byte_in[6:0];
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  case (state_q)
                     StCmd: begin
                        op_d       = byte_in;
                        byte_cnt_d = '0;
                        state_d    = StIgnore;
                        if (!wip || byte_in == OP_RDSR) begin
                           case (byte_in)
                              OP_WREN: wel_d = 1'b1;
                              OP_WRDI: wel_d = 1'b0;
                              OP_RDSR: begin
                                 shift_out_d = status;
                                 state_d     = StTxFixed;
                              end
                              OP_RDID: begin
                                 shift_out_d = JEDEC_ID[23:16];
                                 byte_cnt_d  = 2'd1;
                                 state_d     = StTxFixed;
                              end
                              OP_READ, OP_PP: state_d = StAddr;
`ifdef SPI_FLASH_RESP_ERASE_EN
                              OP_SE: state_d = StAddr;
`endif
                              default: ;
                           endcase
                        end
                     end
                     StAddr: begin
                        addr_sh_d  = addr_full[ADDR_W-9:0];
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                           ptr_d = addr_full;
                           if (op_q == OP_READ) begin
                              mem_addr_d = addr_full;
                              mem_re_d   = 1'b1;
                              ptr_d      = addr_full + ADDR_W'(1);
                              state_d    = StRdData;
                           end else if (op_q == OP_PP) begin
                              state_d = wel_q ? StPpData : StIgnore;
                           end else begin
                              state_d = StIgnore;
`ifdef SPI_FLASH_RESP_ERASE_EN
                              se_pend_d = wel_q;
`endif
                           end
                        end
                     end
                     StRdData: begin
                        mem_addr_d = ptr_q;
                        mem_re_d   = 1'b1;
                        ptr_d      = ptr_q + ADDR_W'(1);
                     end
                     StPpData: begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = byte_in;
                        mem_addr_d  = ptr_q;
                        // Offset wraps inside the 256-byte page.
                        ptr_d       = {ptr_q[ADDR_W-1:8], ptr_q[7:0] + 8'd1};
                     end
                     StTxFixed: begin
                        if (op_q == OP_RDSR) begin
                           shift_out_d = status;
                        end else begin
                           case (byte_cnt_q)
                              2'd1:    shift_out_d = JEDEC_ID[15:8];
                              2'd2:    shift_out_d = JEDEC_ID[7:0];
                              default: shift_out_d = 8'h00;
                           endcase
                           if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            // A byte completing in the same cycle is honoured before leaving.
            if (csn_q) begin
               state_d = StIdle;
               if (state_q == StPpData) wel_d = 1'b0;
`ifdef SPI_FLASH_RESP_ERASE_EN
               if (se_pend_d) begin
                  state_d     = StErase;
                  se_pend_d   = 1'b0;
                  wip_d       = 1'b1;
                  erase_cnt_d = '0;
               end
`endif
            end
         end
      endcase

`ifdef SPI_FLASH_RESP_ERASE_EN
      // Erase engine runs independently so RDSR can poll while it is active.
      if (wip_q) begin
         mem_we_d    = 1'b1;
         mem_wdata_d = 8'hFF;
         mem_addr_d  = {ptr_q[ADDR_W-1:12], erase_cnt_q};
         erase_cnt_d = erase_cnt_q + 12'd1;
         if (&erase_cnt_q) begin
            wip_d = 1'b0;
            wel_d = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         miso_q      <= 1'b0;
         op_q        <= '0;
         addr_sh_q   <= '0;
         ptr_q       <= '0;
         wel_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rd_cap_q    <= 1'b0;
`ifdef SPI_FLASH_RESP_ERASE_EN
         wip_q       <= 1'b0;
         se_pend_q   <= 1'b0;
         erase_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         miso_q      <= miso_d;
         op_q        <= op_d;
         addr_sh_q   <= addr_sh_d;
         ptr_q       <= ptr_d;
         wel_q       <= wel_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rd_cap_q    <= rd_cap_d;
`ifdef SPI_FLASH_RESP_ERASE_EN
         wip_q       <= wip_d;
         se_pend_q   <= se_pend_d;
         erase_cnt_q <= erase_cnt_d;
`endif
      end
   end

   assign miso_o      = miso_q;
   assign miso_oe_o   = ~csn_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_we_o    = mem_we_q;
   assign mem_re_o    = mem_re_q;
   assign busy_o      = wip;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: SPI master tasks at SCK = clk/8, a RAM behind the memory
// port, and a flash-level model (WEL flag, expected memory image, expected write list).
module tb_spi_flash_resp;

   localparam int          HALF  = 4;
   localparam logic [23:0] JEDEC = 24'hEF4016;

   logic        clk = 1'b0, rstn = 1'b0, sck = 1'b0, csn = 1'b1, mosi = 1'b0;
   logic        miso, miso_oe, mem_we, mem_re, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   bit [7:0]    ram     [65536];
   bit          ram_wr  [65536];
   bit [7:0]    ref_mem [65536];
   bit          ref_wr  [65536];
   bit          model_wel = 1'b0;
   logic [23:0] act_wr  [$];
   logic [7:0]  pp_buf  [8];

   spi_flash_resp #(.ADDR_W(16), .JEDEC_ID(JEDEC)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .sck_i       (sck),
      .csn_i       (csn),
      .mosi_i      (mosi),
      .miso_o      (miso),
      .miso_oe_o   (miso_oe),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_we_o    (mem_we),
      .mem_re_o    (mem_re),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Unwritten RAM locations read back as their own low address byte.
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]    <= mem_wdata;
         ram_wr[mem_addr] <= 1'b1;
         act_wr.push_back({mem_addr, mem_wdata});
      end
      if (mem_re) mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
   end

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_wr[a] ? ref_mem[a] : a[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_begin();
      csn = 1'b0;
      tick(4);
   endtask

   task automatic cs_end();
      tick(4);
      csn = 1'b1;
      tick(8);
   endtask

   task automatic xfer_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = tx[i];
         tick(HALF);
         rx[i] = miso;
         sck = 1'b1;
         tick(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      xfer_bits(tx, 8, rx);
   endtask

   task automatic do_cmd(input logic [7:0] op);
      logic [7:0] rx;
      cs_begin();
      xfer(op, rx);
      cs_end();
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
      logic [7:0] rx;
      xfer(op, rx);
      xfer(addr[23:16], rx);
      xfer(addr[15:8], rx);
      xfer(addr[7:0], rx);
   endtask

   task automatic do_rdsr(input bit wip_exp);
      logic [7:0] rx;
      cs_begin();
      xfer(8'h05, rx);
      for (int i = 0; i < 2; i++) begin
         xfer(8'h00, rx);
         check("rdsr", rx, {6'b0, model_wel, wip_exp});
      end
      cs_end();
   endtask

   task automatic do_rdid();
      logic [7:0] rx;
      cs_begin();
      check("miso_oe_low_cs", miso_oe, 1'b1);
      xfer(8'h9F, rx);
      for (int i = 0; i < 5; i++) begin
         xfer(8'h00, rx);
         check("rdid", rx, (i < 3) ? JEDEC[23-8*i -: 8] : 8'h00);
      end
      cs_end();
      check("miso_oe_high_cs", miso_oe, 1'b0);
   endtask

   task automatic do_read(input logic [23:0] addr, input int n);
      logic [7:0] rx;
      cs_begin();
      send_hdr(8'h03, addr);
      for (int i = 0; i < n; i++) begin
         xfer(8'h00, rx);
         check("read", rx, ref_rd(addr[15:0] + 16'(i)));
      end
      cs_end();
   endtask

   task automatic do_pp(input logic [23:0] addr, input int n);
      logic [7:0]  rx;
      logic [15:0] a;
      int          base;
      base = act_wr.size();
      cs_begin();
      send_hdr(8'h02, addr);
      for (int i = 0; i < n; i++) xfer(pp_buf[i], rx);
      cs_end();
      check("pp_count", act_wr.size() - base, model_wel ? n : 0);
      if (model_wel) begin
         for (int i = 0; i < n; i++) begin
            a = {addr[15:8], addr[7:0] + 8'(i)};
            check("pp_write", act_wr[base+i], {a, pp_buf[i]});
            ref_mem[a] = pp_buf[i];
            ref_wr[a]  = 1'b1;
         end
      end
      model_wel = 1'b0;
   endtask

   initial begin
      logic [7:0]  rx;
      logic [23:0] addr;
      int          n, base, errs;

      tick(3);
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_re", mem_re, 1'b0);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_wdata", mem_wdata, 8'h00);
      check("rst_busy", busy, 1'b0);
      rstn = 1'b1;
      tick(4);

      do_rdid();
      do_read(24'h00FFFE, 4);
      do_rdsr(1'b0);

      do_cmd(8'h06);
      model_wel = 1'b1;
      pp_buf[0] = 8'hA1; pp_buf[1] = 8'hA2; pp_buf[2] = 8'hA3;
      do_pp(24'h0000FE, 3);
      do_rdsr(1'b0);

      pp_buf[0] = 8'h11; pp_buf[1] = 8'h22;
      do_pp(24'h000010, 2);
      do_rdsr(1'b0);

      do_cmd(8'h06);
      do_cmd(8'h04);
      do_rdsr(1'b0);

      // Page program aborted five bits into its second data byte.
      do_cmd(8'h06);
      model_wel = 1'b1;
      base = act_wr.size();
      cs_begin();
      send_hdr(8'h02, 24'h000300);
      xfer(8'h5A, rx);
      xfer_bits(8'hC3, 5, rx);
      cs_end();
      check("partial_count", act_wr.size() - base, 1);
      check("partial_write", act_wr[base], {16'h0300, 8'h5A});
      ref_mem[16'h0300] = 8'h5A;
      ref_wr[16'h0300]  = 1'b1;
      model_wel = 1'b0;
      do_rdsr(1'b0);
      do_rdid();
      do_read(24'h0002FF, 3);

`ifndef SPI_FLASH_RESP_ERASE_EN
      do_cmd(8'h06);
      model_wel = 1'b1;
      base = act_wr.size();
      cs_begin();
      send_hdr(8'h20, 24'h001234);
      cs_end();
      check("se_off_count", act_wr.size() - base, 0);
      check("se_off_busy", busy, 1'b0);
      do_rdsr(1'b0);
      do_cmd(8'h04);
      model_wel = 1'b0;
      do_rdsr(1'b0);
`endif

      for (int it = 0; it < 6; it++) begin
         addr = {8'($urandom), 16'($urandom)};
         if ($urandom_range(0, 1) == 1) addr[7:0] = 8'hFD;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) pp_buf[i] = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_cmd(8'h06);
            model_wel = 1'b1;
         end
         do_pp(addr, n);
         do_rdsr(1'b0);
         do_read({addr[23:8], 8'hFC}, 8);
      end

`ifdef SPI_FLASH_RESP_ERASE_EN
      do_cmd(8'h06);
      model_wel = 1'b1;
      base = act_wr.size();
      cs_begin();
      send_hdr(8'h20, 24'h001234);
      cs_end();
      do_rdsr(1'b1);
      for (int k = 0; k < 6000 && busy; k++) tick(1);
      check("erase_done", busy, 1'b0);
      check("erase_count", act_wr.size() - base, 4096);
      errs = 0;
      for (int i = 0; i < 4096 && base + i < act_wr.size(); i++) begin
         if (act_wr[base+i] !== {16'h1000 + 16'(i), 8'hFF}) errs++;
         ref_mem[16'h1000 + 16'(i)] = 8'hFF;
         ref_wr[16'h1000 + 16'(i)]  = 1'b1;
      end
      check("erase_writes", errs, 0);
      model_wel = 1'b0;
      do_rdsr(1'b0);
      do_read(24'h000FFE, 4);

      do_cmd(8'h06);
      cs_begin();
      send_hdr(8'h20, 24'h002000);
      cs_end();
      tick(50);
      check("erase2_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      check("erase_reset_busy", busy, 1'b0);
      tick(2);
      rstn = 1'b1;
      model_wel = 1'b0;
      tick(4);
      do_rdsr(1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_flash_resp.md
# spi_flash_resp

SPI-mode-0 responder that emulates a subset of a serial NOR flash, backed by an external byte-wide synchronous RAM port. It sits on the far side of the DFU application's SPI master (sck/csn/mosi/miso) and replaces the real flash in loopback bring-up and in simulation. It decodes READ, PAGE PROGRAM, ID, status and write-enable commands. All SPI signals are oversampled in the single system clock domain.

## Interface
- ADDR_W, 16: RAM address width; the SPI 24-bit address uses only bits [ADDR_W-1:0].
- JEDEC_ID, 24'hEF4016: the three bytes returned by RDID, MSB first.

- clk_i  in  1  system clock; must be ≥ 8× SCK frequency.
- rstn_i  in  1  asynchronous active-low reset.
- sck_i  in  1  SPI clock, asynchronous to clk_i.
- csn_i  in  1  SPI chip select, active low, asynchronous.
- mosi_i  in  1  SPI data from master, asynchronous.
- miso_o  out  1  SPI data to master.
- miso_oe_o  out  1  MISO output enable; 1 while synchronized csn is low.
- mem_addr_o  out  ADDR_W  RAM byte address.
- mem_wdata_o  out  8  RAM write data.
- mem_we_o  out  1  RAM write strobe, one cycle per byte.
- mem_re_o  out  1  RAM read strobe; mem_rdata_i is valid the following cycle.
- mem_rdata_i  in  8  RAM read data.
- busy_o  out  1  status WIP bit.

## Operation
- sck_i, csn_i and mosi_i each pass through a 2-FF synchronizer. SCK rise and fall are detected from the synchronized value and the value one cycle earlier.
- MOSI is sampled on detected SCK rise, MSB first. MISO shifts on detected SCK fall. The MSB of each output byte is loaded on the fall that follows the 8th rise of the preceding byte.
- Status register: bit0 WIP, bit1 WEL, other bits 0.
- FSM states: IDLE, CMD, ADDR, RD_DATA, PP_DATA, TX_FIXED (RDID/RDSR), IGNORE, ERASE.
- IDLE: entered whenever synchronized csn is high. Bit counter cleared; shift register cleared; miso_o = 0.
- CMD: after 8 bits, dispatch on the opcode:
  - 0x06 WREN: sets WEL.
  - 0x04 WRDI: clears WEL.
  - 0x05 RDSR: goes to TX_FIXED, repeating the status byte.
  - 0x9F RDID: goes to TX_FIXED, sending JEDEC_ID bytes 2,1,0, then 0x00 repeated.
  - 0x03 READ, 0x02 PP, 0x20 SE: go to ADDR.
  - Any other opcode: goes to IGNORE.
- ADDR: collects 24 bits.
  - READ: mem_re_o pulses with the address on the 24th rise and goes to RD_DATA.
  - PP: goes to PP_DATA if WEL=1, otherwise IGNORE.
  - SE: waits for csn high, then goes to ERASE if WEL=1, otherwise IDLE.
- RD_DATA: mem_rdata_i is latched into the output shift register. The address increments mod 2^ADDR_W and the next mem_re_o is issued at each byte boundary (8th rise). Reads stream indefinitely.
- PP_DATA: each complete byte produces a one-cycle mem_we_o. The address is {page base, offset} and the offset increments mod 256, so writes wrap within the page. Data is written directly; there is no AND-with-old emulation. WEL clears on csn rise.
- While WIP=1, every opcode except RDSR goes to IGNORE.
- csn rising mid-byte: the partial byte is discarded and no write occurs; the FSM returns to IDLE, or to ERASE if it is pending.
- Reset values: miso_o 0, miso_oe_o 0, mem_we_o 0, mem_re_o 0, mem_addr_o 0, mem_wdata_o 0, busy_o 0, WEL 0, FSM IDLE.

## Timing
- SCK edge detect latency: 3 clk_i from pin to action.
- MISO latency: the new bit appears at most 4 clk_i after the SCK falling pin edge. This requires SCK half-period ≥ 4 clk_i.
- READ: mem_re_o fires 3 clk_i after the 24th SCK rise, and data is captured one cycle later. It is ready before the next fall under the clock-ratio rule.
- PP: mem_we_o fires 3 clk_i after each 8th rise.
- Simultaneous byte-complete and csn rise in the same cycle: the byte completes first (write or strobe is issued), then the FSM goes to IDLE.

## Configuration
- SPI_FLASH_RESP_ERASE_EN defined:
  - 0x20 SE erases the 4 KiB sector containing the address.
  - ERASE writes 0xFF to one byte per clk_i, using a 12-bit counter, for 4096 cycles.
  - WIP=1 during the erase; WIP and WEL both clear on completion.
  - The erase continues regardless of csn. A reset during erase aborts it.
- Not defined: 0x20 is an unknown opcode and goes to IGNORE; the ERASE state and its counter are absent; WIP is constant 0.

## Structure
- Shared package spi_flash_pkg holds:
  - opcode constants (OP_READ, OP_PP, OP_SE, OP_WREN, OP_WRDI, OP_RDSR, OP_RDID);
  - the FSM state encoding;
  - status bit indices (SR_WIP, SR_WEL).
- One sub-module, spi_sync_edge: a 2-FF synchronizer plus rise/fall detect, instantiated for sck_i. csn_i and mosi_i use plain synchronizers.

## Test plan
- RDID with SCK = clk/8 → MISO bytes 0xEF, 0x40, 0x16, then 0x00.
- WREN; PP 0x0000FE with 0xA1 0xA2 0xA3 → mem_we_o at 0xFE, 0xFF, 0x00 (page wrap), data A1/A2/A3; then RDSR → 0x00 (WEL cleared).
- PP without a prior WREN → no mem_we_o pulses; RDSR → 0x00.
- RAM preloaded with addr[7:0] at each address; READ 0x00FFFE for 4 bytes with ADDR_W=16 → MISO 0xFE, 0xFF, 0x00, 0x01.
- csn raised after 5 bits of a PP data byte → no write for that byte; the next command decodes correctly.
- With SPI_FLASH_RESP_ERASE_EN: WREN; SE 0x001234 → mem_we_o 4096 times over 0x1000–0x1FFF with data 0xFF; RDSR during the erase → 0x03; after completion → 0x00. Reset asserted mid-erase → busy_o = 0 immediately.
